// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: MD op codes, default
// latencies and the op-class decode used by both the controller and the
// hazard logic. Optional macro MDU_MADD_EN enables madd/maddu/msub/msubu.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_op_e;

  localparam int MDU_MULT_CYC = 5;
  localparam int MDU_DIV_CYC  = 10;

  // Ops that occupy the unit for the multiply latency; the accumulate ops
  // only join this class when they are built in, otherwise they are no-ops.
  function automatic logic is_mult_class(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Ops that occupy the unit for the divide latency.
  function automatic logic is_div_class(input logic [3:0] op);
    case (op)
      MD_DIV, MD_DIVU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational datapath of the multiply/divide unit. Produces the 64-bit
// {HI,LO} result for an MD op and flags divide-by-zero. Accumulate results
// are always computed here; whether they are ever latched is decided by the
// controller's decode (macro MDU_MADD_EN).
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        dz
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [63:0]        acc;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;

  // Compute every candidate result, then select by op. The low 64 bits of
  // a product of sign-extended operands equal the signed 32x32 product.
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'b0, a} * {32'b0, b};
    acc    = {hi, lo};
    dz     = (b == 32'b0);
    q_s    = '0;
    r_s    = '0;
    q_u    = '0;
    r_u    = '0;
    if (!dz) begin
      q_s = $signed(a) / $signed(b);
      r_s = $signed(a) % $signed(b);
      q_u = a / b;
      r_u = a % b;
    end
    res = '0;
    case (md_op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV:   res = {r_s, q_s};
      MD_DIVU:  res = {r_u, q_u};
      MD_MADD:  res = acc + prod_s;
      MD_MADDU: res = acc + prod_u;
      MD_MSUB:  res = acc - prod_s;
      MD_MSUBU: res = acc - prod_u;
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: owns HI/LO, sequences multi-cycle MD ops
// with a down-counter (IDLE when cnt==0, RUN otherwise) and drives busy/hold
// for the hazard unit. Optional macro MDU_MADD_EN enables ops 9-12.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MDU_MULT_CYC,
  parameter int DIV_CYC  = MDU_DIV_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        hold,
  output logic [31:0] MDOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      tmp_q, tmp_d;
  logic             dz_q, dz_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [63:0]      calc_res;
  logic             calc_dz;
  logic             mult_op;
  logic             div_op;

  mdu_calc u_calc (
    .md_op (MDOp),
    .a     (A),
    .b     (B),
    .hi    (hi_q),
    .lo    (lo_q),
    .res   (calc_res),
    .dz    (calc_dz)
  );

  assign mult_op = is_mult_class(MDOp);
  assign div_op  = is_div_class(MDOp);

  // Next-state: count down while running and commit tmp on the last edge;
  // in idle, launch mult/div ops or perform the single-edge HI/LO moves.
  // A start while running is dropped since the hazard unit prevents it.
  always_comb begin
    cnt_d = cnt_q;
    tmp_d = tmp_q;
    dz_d  = dz_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && !dz_q) begin
        hi_d = tmp_q[63:32];
        lo_d = tmp_q[31:0];
      end
    end else if (start) begin
      if (mult_op) begin
        cnt_d = CNT_W'(MULT_CYC);
        tmp_d = calc_res;
        dz_d  = 1'b0;
      end else if (div_op) begin
        cnt_d = CNT_W'(DIV_CYC);
        tmp_d = calc_res;
        dz_d  = calc_dz;
      end else if (MDOp == MD_MTHI) begin
        hi_d = A;
      end else if (MDOp == MD_MTLO) begin
        lo_d = A;
      end
    end
  end

  // State registers with synchronous reset; reset drops any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tmp_q <= '0;
      dz_q  <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      tmp_q <= tmp_d;
      dz_q  <= dz_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  // Read port for mfhi/mflo straight from the architectural registers.
  always_comb begin
    MDOut = '0;
    if (MDOp == MD_MFHI)      MDOut = hi_q;
    else if (MDOp == MD_MFLO) MDOut = lo_q;
  end

  assign busy = (cnt_q != '0);
  assign hold = busy | (start & (mult_op | div_op));
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: a table of directed MD ops with
// hand-computed HI/LO/latency, plus sequences for reset mid-divide and
// hold/mflo back-to-back timing. Honours MDU_MADD_EN for the madd entry.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        hold;
  logic [31:0] MDOut;
  logic [31:0] HI;
  logic [31:0] LO;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        expHold;
    int          expCyc;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  vec_t vecs[12];

  mdu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .hold  (hold),
    .MDOut (MDOut),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  // A start while the unit is busy must never be presented.
  always @(posedge clk) begin
    if (!reset && busy && start) begin
      nFail++;
      $display("[TB] FAIL start_while_busy: start=%0b busy=%0b, required no start while busy", start, busy);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one op for a single start cycle, then count busy cycles.
  task automatic applyStimulus(input vec_t v, output int cyc);
    @(negedge clk);
    MDOp  = v.op;
    A     = v.a;
    B     = v.b;
    start = 1'b1;
    #1;
    checkOutput("hold_start_cycle", {31'b0, hold}, {31'b0, v.expHold});
    @(posedge clk);
    #1;
    start = 1'b0;
    MDOp  = 4'd0;
    cyc   = 0;
    @(negedge clk);
    while (busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{4'd1,  32'hFFFFFFFF, 32'h00000002, 1'b1, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{4'd2,  32'hFFFFFFFF, 32'h00000002, 1'b1, 5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{4'd3,  32'hFFFFFFF9, 32'h00000002, 1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{4'd4,  32'h00000007, 32'h00000000, 1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{4'd3,  32'd100,      32'hFFFFFFF9, 1'b1, 10, 32'h00000002, 32'hFFFFFFF2};
    vecs[5]  = '{4'd5,  32'h12345678, 32'h0,        1'b0, 0,  32'h12345678, 32'hFFFFFFF2};
    vecs[6]  = '{4'd6,  32'hFFFFFFFF, 32'h0,        1'b0, 0,  32'h12345678, 32'hFFFFFFFF};
    vecs[7]  = '{4'd5,  32'h00000000, 32'h0,        1'b0, 0,  32'h00000000, 32'hFFFFFFFF};
`ifdef MDU_MADD_EN
    vecs[8]  = '{4'd9,  32'h00000001, 32'h00000001, 1'b1, 5,  32'h00000001, 32'h00000000};
`else
    vecs[8]  = '{4'd9,  32'h00000001, 32'h00000001, 1'b0, 0,  32'h00000000, 32'hFFFFFFFF};
`endif
    vecs[9]  = '{4'd13, 32'hDEADBEEF, 32'h00000003, 1'b0, 0,  vecs[8].expHi, vecs[8].expLo};
    vecs[10] = '{4'd1,  32'h00010000, 32'h00010000, 1'b1, 5,  32'h00000001, 32'h00000000};
    vecs[11] = '{4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5,  32'hFFFFFFFE, 32'h00000001};

    reset = 1'b1;
    start = 1'b0;
    MDOp  = 4'd0;
    A     = '0;
    B     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy",  {31'b0, busy}, 32'd0);
    checkOutput("reset_hold",  {31'b0, hold}, 32'd0);
    checkOutput("reset_hi",    HI,    32'd0);
    checkOutput("reset_lo",    LO,    32'd0);
    checkOutput("reset_mdout", MDOut, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], cyc);
      checkOutput($sformatf("v%0d_busy_cycles", i), cyc, vecs[i].expCyc);
      checkOutput($sformatf("v%0d_hi", i), HI, vecs[i].expHi);
      checkOutput($sformatf("v%0d_lo", i), LO, vecs[i].expLo);
      checkOutput($sformatf("v%0d_mdout_none", i), MDOut, 32'd0);
      MDOp  = 4'd7;
      start = 1'b1;
      #1;
      checkOutput($sformatf("v%0d_mfhi", i), MDOut, vecs[i].expHi);
      checkOutput($sformatf("v%0d_mfhi_hold", i), {31'b0, hold}, 32'd0);
      MDOp = 4'd8;
      #1;
      checkOutput($sformatf("v%0d_mflo", i), MDOut, vecs[i].expLo);
      start = 1'b0;
      MDOp  = 4'd0;
    end

    // Reset during a divide: result discarded, HI/LO cleared, no late write.
    @(negedge clk);
    MDOp  = 4'd3;
    A     = 32'd100;
    B     = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    MDOp  = 4'd0;
    @(negedge clk);
    checkOutput("rst_mid_busy_t1", {31'b0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_mid_hi", HI, 32'd0);
    checkOutput("rst_mid_lo", LO, 32'd0);
    repeat (15) @(negedge clk);
    checkOutput("rst_mid_late_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_mid_late_hi", HI, 32'd0);
    checkOutput("rst_mid_late_lo", LO, 32'd0);

    // mult at t, hold through t+5, mflo at t+6 sees the product.
    @(negedge clk);
    MDOp  = 4'd1;
    A     = 32'd3;
    B     = 32'd5;
    start = 1'b1;
    #1;
    checkOutput("bb_hold_t", {31'b0, hold}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    MDOp  = 4'd0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("bb_hold_t%0d", k), {31'b0, hold}, 32'd1);
      checkOutput($sformatf("bb_lo_old_t%0d", k), LO, 32'd0);
    end
    @(negedge clk);
    MDOp  = 4'd8;
    start = 1'b1;
    #1;
    checkOutput("bb_hold_t6",  {31'b0, hold}, 32'd0);
    checkOutput("bb_mflo_t6",  MDOut, 32'd15);
    checkOutput("bb_hi_t6",    HI,    32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    MDOp  = 4'd0;
    @(negedge clk);
    checkOutput("bb_after_busy", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
